// File: rtl/zero_scan_unit_pkg.sv
// Shared encodings for the zero/ones/leading/trailing scan unit.
// Holds the operating modes, FSM states and the result-width helper.
package zero_scan_unit_pkg;

  typedef enum logic [1:0] {
    MODE_ZERO = 2'b00,
    MODE_ONES = 2'b01,
    MODE_LZC  = 2'b10,
    MODE_TZC  = 2'b11
  } scan_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_DONE = 2'b10
  } scan_state_e;

  // A count of 0..width needs this many bits.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/zero_scan_unit_if.sv
// Operand/result handshake bundle for zero_scan_unit.
// The master offers operands and takes results; the unit is the slave.
interface zero_scan_unit_if #(
  parameter int WIDTH = 32
) ();
  localparam int CW = zero_scan_unit_pkg::count_width(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic             out_flag;
  logic [CW-1:0]    out_count;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_flag, out_count
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_flag, out_count
  );
endinterface

// File: rtl/zero_scan_unit_chunk_scan.sv
// Combinational summary of one CHUNK-bit slice: popcount, all-zero/all-ones
// and the zero runs measured from either end (CHUNK when the slice is zero).
module chunk_scan #(
  parameter  int CHUNK = 8,
  localparam int PW    = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] data,
  output logic [PW-1:0]    pop,
  output logic             all_zero,
  output logic             all_ones,
  output logic [PW-1:0]    lead_zeros,
  output logic [PW-1:0]    trail_zeros
);

  // Later iterations overwrite earlier ones, so the highest set bit wins for
  // the leading run and the lowest set bit wins for the trailing run.
  always_comb begin
    pop         = '0;
    lead_zeros  = PW'(CHUNK);
    trail_zeros = PW'(CHUNK);
    for (int i = 0; i < CHUNK; i++) begin
      pop = pop + PW'(data[i]);
      if (data[i]) lead_zeros = PW'(CHUNK - 1 - i);
    end
    for (int j = CHUNK - 1; j >= 0; j--) begin
      if (data[j]) trail_zeros = PW'(j);
    end
  end

  assign all_zero = ~|data;
  assign all_ones = &data;

endmodule

// File: rtl/zero_scan_unit.sv
// Multi-cycle zero/ones detect, popcount and leading/trailing zero count.
// Scans one CHUNK per cycle for a fixed N cycles, then holds the result.
module zero_scan_unit
  import zero_scan_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic              clock,
  input logic              reset_n,
  zero_scan_unit_if.slave  bus
);

  localparam int N    = WIDTH / CHUNK;
  localparam int CW   = count_width(WIDTH);
  localparam int PW   = $clog2(CHUNK + 1);
  localparam int CNTW = (N > 1) ? $clog2(N) : 1;

  scan_state_e      state_q, state_nxt;
  scan_mode_e       mode_q;
  logic [WIDTH-1:0] shift_q;
  logic [CNTW-1:0]  chunk_idx_q;
  logic [CW-1:0]    count_q, count_nxt;
  logic             flag_q, flag_nxt;
  logic             found_q, found_nxt;
  logic [CW-1:0]    out_count_q;
  logic             out_flag_q;

  logic [CHUNK-1:0] chunk_data;
  logic [PW-1:0]    chunk_pop, chunk_lz, chunk_tz;
  logic             chunk_zero, chunk_ones;
  logic             last_chunk;
  logic             in_ready_c, out_valid_c;

  // Leading-zero mode walks from the MSB end, every other mode from the LSB.
  assign chunk_data = (mode_q == MODE_LZC) ? shift_q[WIDTH-1 -: CHUNK]
                                           : shift_q[CHUNK-1:0];
  assign last_chunk = (chunk_idx_q == CNTW'(N - 1));

  chunk_scan #(.CHUNK(CHUNK)) u_chunk_scan (
    .data        (chunk_data),
    .pop         (chunk_pop),
    .all_zero    (chunk_zero),
    .all_ones    (chunk_ones),
    .lead_zeros  (chunk_lz),
    .trail_zeros (chunk_tz)
  );

  // Zero runs keep growing until the first chunk holding a one, then freeze.
  always_comb begin
    count_nxt = count_q;
    flag_nxt  = flag_q;
    found_nxt = found_q;
    case (mode_q)
      MODE_ZERO: begin
        count_nxt = count_q + CW'(chunk_pop);
        flag_nxt  = flag_q & chunk_zero;
      end
      MODE_ONES: begin
        count_nxt = count_q + CW'(chunk_pop);
        flag_nxt  = flag_q & chunk_ones;
      end
      default: begin
        flag_nxt = flag_q & chunk_zero;
        if (!found_q) begin
          count_nxt = count_q + CW'((mode_q == MODE_LZC) ? chunk_lz : chunk_tz);
          found_nxt = !chunk_zero;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_nxt;
  end

  always_comb begin
    state_nxt   = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready_c = reset_n;
        if (bus.in_valid && in_ready_c) state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        if (last_chunk) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The published result only changes when a scan completes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q      <= MODE_ZERO;
      shift_q     <= '0;
      chunk_idx_q <= '0;
      count_q     <= '0;
      flag_q      <= 1'b0;
      found_q     <= 1'b0;
      out_count_q <= '0;
      out_flag_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            shift_q     <= bus.in_data;
            mode_q      <= scan_mode_e'(bus.in_mode);
            chunk_idx_q <= '0;
            count_q     <= '0;
            flag_q      <= 1'b1;
            found_q     <= 1'b0;
          end
        end
        ST_SCAN: begin
          shift_q     <= (mode_q == MODE_LZC) ? (shift_q << CHUNK) : (shift_q >> CHUNK);
          chunk_idx_q <= chunk_idx_q + CNTW'(1);
          count_q     <= count_nxt;
          flag_q      <= flag_nxt;
          found_q     <= found_nxt;
          if (last_chunk) begin
            out_count_q <= count_nxt;
            out_flag_q  <= flag_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_flag  = out_flag_q;
  assign bus.out_count = out_count_q;

endmodule

// File: tb/tb_zero_scan_unit.sv
// Directed bench for zero_scan_unit: a 32/8 instance and a 64/16 instance
// sharing clock and reset, checked against hand-computed results.
module tb_zero_scan_unit;

  logic clock;
  logic reset_n;
  int   n_compared   = 0;
  int   n_mismatched = 0;

  zero_scan_unit_if #(.WIDTH(32)) bus ();
  zero_scan_unit_if #(.WIDTH(64)) bus_wide ();

  zero_scan_unit #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  zero_scan_unit #(.WIDTH(64), .CHUNK(16)) u_dut_wide (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_wide)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Offers an operand at the current falling edge; returns one cycle later,
  // after the acceptance edge, with garbage left on in_data.
  task automatic apply_stimulus(input logic [1:0] mode, input logic [31:0] data);
    bus.in_valid = 1'b1;
    bus.in_mode  = mode;
    bus.in_data  = data;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.in_data  = 32'hDEAD_BEEF;
    bus.in_mode  = ~mode;
  endtask

  task automatic wait_result(input string tag, input logic exp_flag,
                             input logic [5:0] exp_count);
    int edges = 0;
    while (!bus.out_valid && edges < 20) begin
      @(negedge clock);
      edges++;
    end
    check_output({tag, " latency"}, 64'(edges), 64'd4);
    check_output({tag, " flag"}, 64'(bus.out_flag), 64'(exp_flag));
    check_output({tag, " count"}, 64'(bus.out_count), 64'(exp_count));
  endtask

  task automatic handshake(input string tag, input logic exp_flag,
                           input logic [5:0] exp_count);
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
    check_output({tag, " valid_clear"}, 64'(bus.out_valid), 64'd0);
    check_output({tag, " ready_back"}, 64'(bus.in_ready), 64'd1);
    check_output({tag, " kept_count"}, 64'(bus.out_count), 64'(exp_count));
    check_output({tag, " kept_flag"}, 64'(bus.out_flag), 64'(exp_flag));
  endtask

  task automatic run_op(input string tag, input logic [1:0] mode,
                        input logic [31:0] data, input logic exp_flag,
                        input logic [5:0] exp_count);
    apply_stimulus(mode, data);
    wait_result(tag, exp_flag, exp_count);
    handshake(tag, exp_flag, exp_count);
  endtask

  task automatic wide_op(input string tag, input logic [1:0] mode,
                         input logic [63:0] data, input logic exp_flag,
                         input logic [6:0] exp_count);
    int edges = 0;
    bus_wide.in_valid = 1'b1;
    bus_wide.in_mode  = mode;
    bus_wide.in_data  = data;
    @(posedge clock);
    @(negedge clock);
    bus_wide.in_valid = 1'b0;
    bus_wide.in_data  = '0;
    while (!bus_wide.out_valid && edges < 20) begin
      @(negedge clock);
      edges++;
    end
    check_output({tag, " latency"}, 64'(edges), 64'd4);
    check_output({tag, " flag"}, 64'(bus_wide.out_flag), 64'(exp_flag));
    check_output({tag, " count"}, 64'(bus_wide.out_count), 64'(exp_count));
    bus_wide.out_ready = 1'b1;
    @(negedge clock);
    bus_wide.out_ready = 1'b0;
    check_output({tag, " valid_clear"}, 64'(bus_wide.out_valid), 64'd0);
    check_output({tag, " ready_back"}, 64'(bus_wide.in_ready), 64'd1);
  endtask

  initial begin
    int seen;
    reset_n            = 1'b0;
    bus.in_valid       = 1'b0;
    bus.in_data        = '0;
    bus.in_mode        = 2'b00;
    bus.out_ready      = 1'b0;
    bus_wide.in_valid  = 1'b0;
    bus_wide.in_data   = '0;
    bus_wide.in_mode   = 2'b00;
    bus_wide.out_ready = 1'b0;

    $display("[TB] reset state");
    repeat (2) @(negedge clock);
    check_output("rst in_ready", 64'(bus.in_ready), 64'd0);
    check_output("rst out_valid", 64'(bus.out_valid), 64'd0);
    check_output("rst out_count", 64'(bus.out_count), 64'd0);
    check_output("rst out_flag", 64'(bus.out_flag), 64'd0);
    check_output("rst wide in_ready", 64'(bus_wide.in_ready), 64'd0);
    reset_n = 1'b1;

    $display("[TB] directed vectors");
    run_op("zd_zero",   2'b00, 32'h0000_0000, 1'b1, 6'd0);
    run_op("od_ones",   2'b01, 32'hFFFF_FFFF, 1'b1, 6'd32);
    run_op("zd_msb",    2'b00, 32'h8000_0000, 1'b0, 6'd1);
    run_op("lz_bit16",  2'b10, 32'h0001_0000, 1'b0, 6'd15);
    run_op("tz_bit16",  2'b11, 32'h0001_0000, 1'b0, 6'd16);
    run_op("lz_zero",   2'b10, 32'h0000_0000, 1'b1, 6'd32);
    run_op("tz_zero",   2'b11, 32'h0000_0000, 1'b1, 6'd32);
    run_op("od_almost", 2'b01, 32'h7FFF_FFFF, 1'b0, 6'd31);
    run_op("zd_mixed",  2'b00, 32'h0F0F_00F1, 1'b0, 6'd13);
    run_op("tz_lsb",    2'b11, 32'h0000_0001, 1'b0, 6'd0);
    run_op("tz_msb",    2'b11, 32'h8000_0000, 1'b0, 6'd31);
    run_op("lz_full",   2'b10, 32'hFFFF_FFFF, 1'b0, 6'd0);
    run_op("lz_lsb",    2'b10, 32'h0000_0001, 1'b0, 6'd31);

    $display("[TB] stall in DONE");
    apply_stimulus(2'b00, 32'h0000_00A5);
    wait_result("stall", 1'b0, 6'd4);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
      bus.in_mode  = 2'b11;
      @(negedge clock);
      check_output("stall valid", 64'(bus.out_valid), 64'd1);
      check_output("stall in_ready", 64'(bus.in_ready), 64'd0);
      check_output("stall count", 64'(bus.out_count), 64'd4);
      check_output("stall flag", 64'(bus.out_flag), 64'd0);
    end
    bus.in_valid = 1'b0;
    handshake("stall", 1'b0, 6'd4);

    $display("[TB] reset during scan");
    apply_stimulus(2'b01, 32'hFFFF_FFFF);
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_output("abort in_ready", 64'(bus.in_ready), 64'd0);
    check_output("abort out_valid", 64'(bus.out_valid), 64'd0);
    check_output("abort out_count", 64'(bus.out_count), 64'd0);
    check_output("abort out_flag", 64'(bus.out_flag), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clock);
      if (bus.out_valid) seen++;
    end
    check_output("abort no_valid", 64'(seen), 64'd0);
    check_output("abort idle_ready", 64'(bus.in_ready), 64'd1);

    $display("[TB] accept right after reset release");
    apply_stimulus(2'b10, 32'h00FF_0000);
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check_output("release in_ready", 64'(bus.in_ready), 64'd1);
    apply_stimulus(2'b11, 32'h0000_0100);
    wait_result("post_reset", 1'b0, 6'd8);
    handshake("post_reset", 1'b0, 6'd8);

    $display("[TB] wide instance");
    wide_op("wide_tz_msb", 2'b11, 64'h8000_0000_0000_0000, 1'b0, 7'd63);
    wide_op("wide_lz_b16", 2'b10, 64'h0000_0000_0001_0000, 1'b0, 7'd47);
    wide_op("wide_ones",   2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 7'd64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/zero_scan_unit.md
ZERO_SCAN_UNIT -- requirements
Module: zero_scan_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, bits examined per scan cycle; WIDTH mod CHUNK == 0, CHUNK >= 1; N = WIDTH/CHUNK.
REQ-003 SHALL have derived localparam CW = clog2(WIDTH+1), count width.
REQ-004 clock  input  1  sole clock, rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  operand offered.
REQ-007 in_ready  output  1  unit can accept operand.
REQ-008 in_data  input  WIDTH  operand.
REQ-009 in_mode  input  2  00 zero-detect, 01 ones-detect, 10 leading-zero count, 11 trailing-zero count.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 out_flag  output  1  mode 00: operand all zero; 01: all ones; 10/11: operand all zero.
REQ-013 out_count  output  CW  modes 00/01: popcount of operand; 10: leading zeros from MSB; 11: trailing zeros from LSB; all-zero operand in 10/11 gives WIDTH.

Function
REQ-014 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE with reset_n high.
REQ-016 Acceptance SHALL occur on a rising edge with in_valid && in_ready; in_data and in_mode are captured; FSM IDLE -> SCAN.
REQ-017 SCAN SHALL process one CHUNK per cycle for exactly N cycles: mode 10 from MSB chunk down, all other modes from LSB chunk up.
REQ-018 Latency SHALL be fixed: out_valid rises N cycles after the acceptance edge (32/8: 4 cycles), independent of data and mode; no early termination.
REQ-019 LZ/TZ accumulation SHALL add a chunk's full CHUNK to the count while no set bit seen, add the chunk-local zero run at the first chunk containing a one, then freeze.
REQ-020 Popcount and flag accumulation SHALL be exact for all WIDTH; count never wraps (max WIDTH fits CW).
REQ-021 After last chunk FSM SHALL enter DONE, out_valid = 1, out_flag/out_count held stable until handshake.
REQ-022 In DONE, out_ready sampled high SHALL clear out_valid and return to IDLE on that edge; in_ready rises the following cycle (no same-cycle re-accept).
REQ-023 out_ready low in DONE SHALL hold state and outputs indefinitely.
REQ-024 in_valid and in_data changes outside acceptance edge SHALL be ignored.
REQ-025 out_flag/out_count SHALL retain last result after handshake until next result.

Reset
REQ-026 reset_n low SHALL immediately force IDLE, out_valid = 0, out_flag = 0, out_count = 0, in_ready = 0, internal accumulators cleared.
REQ-027 Reset asserted during SCAN or DONE SHALL abort the operation; no out_valid for it after release.
REQ-028 First acceptance SHALL be possible on the first rising edge after reset_n deasserts.

Structure
REQ-029 Mode encodings, FSM state encodings and CW computation SHALL live in the shared ALU package/header.
REQ-030 One combinational sub-module chunk_scan (CHUNK-bit input -> popcount, all-zero, all-ones, leading-zero run, trailing-zero run) SHALL be instantiated once.
REQ-031 Datapath registers: operand shift register, mode, chunk counter (clog2 N bits), count and flag accumulators.

Verification
REQ-032 mode 00, in_data 0x00000000 -> after 4 cycles out_valid=1, out_flag=1, out_count=0.
REQ-033 mode 01, 0xFFFFFFFF -> out_flag=1, out_count=32; mode 00, 0x80000000 -> out_flag=0, out_count=1.
REQ-034 mode 10, 0x00010000 -> out_count=15, out_flag=0; mode 11 same data -> out_count=16; mode 10, 0x00000000 -> out_count=32, out_flag=1.
REQ-035 out_ready held low 10 cycles in DONE -> outputs stable, in_ready=0; out_ready high -> out_valid falls, in_ready=1 next cycle.
REQ-036 reset_n pulsed low at SCAN cycle 2 -> out_valid never asserts, in_ready=0 during reset, new operand accepted first edge after release.
REQ-037 WIDTH=64, CHUNK=16, mode 11, 0x8000000000000000 -> out_valid 4 cycles after accept, out_count=63.
